sn_noise_channel: RTL and testbench
===================================

# sn_noise_channel

Parametrised noise channel for the SN76489-compatible sound core. It combines the noise rate divider and the noise shift register in one synchronous block. Timing comes from a single clock plus a tone-rate clock enable, so the block derives no clocks. It adds configurable LFSR width, seed and taps, divider ratios, a control-write reset of the shift register, a shift strobe and a 4-bit attenuated output level for the mixer.

## Interface
Parameters:
- LFSR_W, default 16: shift register width (≥4).
- TAP_A, default 15: primary tap; must equal LFSR_W-1 (the output bit).
- TAP_B, default 12: secondary tap, used only in white mode; 0 ≤ TAP_B < TAP_A.
- SEED, default 1: LFSR reload value; must be non-zero.
- DIV0 / DIV1 / DIV2, defaults 32 / 64 / 128: shift periods in `ce` ticks for rate codes 0/1/2; each ≥2 and ≤256.

Ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- ce, in, 1: tone-rate clock enable, one `clk` cycle wide.
- tone3_stb, in, 1: one-cycle pulse on each tone-channel-3 output toggle.
- ctrl_we, in, 1: noise control write strobe.
- ctrl_data, in, 3: bit2 is mode (1 = white, 0 = periodic); bits1:0 are the rate code.
- atten_we, in, 1: attenuation write strobe.
- atten_data, in, 4: attenuation (0 = loudest, 15 = off).
- noise_out, out, 1: LFSR[LFSR_W-1], registered.
- shift_stb, out, 1: one-cycle pulse in the cycle after each LFSR shift.
- level, out, 4: equals noise_out ? ~atten : 0, registered.

## Operation
- Registers: lfsr[LFSR_W-1:0], cnt[7:0], mode, rate[1:0], atten[3:0].
- Reset values (async, while rst_n=0):
  - lfsr=SEED, cnt=0, mode=0, rate=0, atten=4'hF.
  - noise_out=SEED[LFSR_W-1], shift_stb=0, level=0.
- Shift event, rates 0–2:
  - On each `ce`, if cnt == DIVn-1 then cnt←0 and a shift occurs; otherwise cnt←cnt+1.
- Shift event, rate 3:
  - Each `tone3_stb` causes a shift; cnt holds at 0 and `ce` is ignored.
- Shift operation:
  - lfsr ← {lfsr[LFSR_W-2:0], fb}.
  - Periodic mode: fb = lfsr[TAP_A].
  - White mode: fb = lfsr[TAP_A] ^ lfsr[TAP_B].
- Control write (ctrl_we=1):
  - mode and rate load from ctrl_data, lfsr←SEED, cnt←0.
  - Any shift due in the same cycle is discarded; the write has priority.
- Attenuation write: atten←atten_data. It is independent of shifts and may coincide with one.
- Zero guard: if lfsr is all-zero at a shift it reloads SEED instead of shifting. This is unreachable with a legal SEED and exists for robustness only.
- Rate-code changes take effect from the cycle after the write; the new divider starts counting from 0.

## Timing
- All state updates on the rising edge of clk; no combinational input-to-output paths.
- Shift latency: a shift triggered by `ce`/`tone3_stb` in cycle N updates lfsr at edge N. noise_out and shift_stb reflect it in cycle N+1, and level also in cycle N+1.
- level tracks both noise_out and atten with one register stage. An atten write in cycle N shows on level in cycle N+1, with the new atten combined with the current noise bit.
- With ce held high at rate 0, shift_stb pulses every DIV0 cycles. The first pulse comes DIV0+1 cycles after reset release or after a control write.
- A ctrl_we during rst_n=0 is ignored. Reset asserted mid-count abandons the count; no shift_stb is emitted.

## Test plan
- Reset: assert rst_n=0 mid-operation. Required: noise_out=0, level=0, shift_stb=0 immediately, and atten reads 15 (level stays 0 even when noise_out=1).
- Periodic, rate 3, defaults: write ctrl=3'b011, atten=0, apply 15 tone3_stb pulses. Required: lfsr=0x8000, noise_out=1, level=15. The 16th pulse gives lfsr=0x0001, noise_out=0, so the period is 16.
- White vs periodic: apply 13 shifts from SEED. Required: white lfsr=0x2001, periodic lfsr=0x2000.
- Divider: ctrl=3'b100 with ce constantly high. Required: shift_stb every 32 cycles, first pulse 33 cycles after the write. Rates 1 and 2 give 64 and 128.
- Write collision: assert ctrl_we in the exact cycle a divider shift is due. Required: no shift_stb next cycle, lfsr=SEED, next shift a full DIVn ticks later.
- Parameter sweep: LFSR_W=15, TAP_B=13, SEED=1, white mode. Required: the sequence repeats with period 32767 and the all-zero state is never observed.

Source files
------------

// File: rtl/sn_noise_channel.sv
// SN76489-style noise channel: rate divider, LFSR with periodic/white feedback,
// shift strobe and attenuated output level, all driven from one clock plus enables.
module sn_noise_channel #(
   parameter int LFSR_W = 16,
   parameter int TAP_A  = 15,
   parameter int TAP_B  = 12,
   parameter int SEED   = 1,
   parameter int DIV0   = 32,
   parameter int DIV1   = 64,
   parameter int DIV2   = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       tone3_stb,
   input  logic       ctrl_we,
   input  logic [2:0] ctrl_data,
   input  logic       atten_we,
   input  logic [3:0] atten_data,
   output logic       noise_out,
   output logic       shift_stb,
   output logic [3:0] level
);

   localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);
   localparam logic [7:0] DIV0_M1 = 8'(DIV0 - 1);
   localparam logic [7:0] DIV1_M1 = 8'(DIV1 - 1);
   localparam logic [7:0] DIV2_M1 = 8'(DIV2 - 1);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic [1:0]        rate_q, rate_d;
   logic [3:0]        atten_q, atten_d;
   logic              noise_out_q, noise_out_d;
   logic              shift_stb_q, shift_stb_d;
   logic [3:0]        level_q, level_d;

   logic [7:0] div_m1;
   logic       shift_due;
   logic       fb;

   always_comb begin
      div_m1 = DIV0_M1;
      case (rate_q)
         2'd1:    div_m1 = DIV1_M1;
         2'd2:    div_m1 = DIV2_M1;
         default: div_m1 = DIV0_M1;
      endcase
   end

   always_comb begin
      shift_due = 1'b0;
      cnt_d     = cnt_q;
      if (rate_q == 2'd3) begin
         shift_due = tone3_stb;
         cnt_d     = 8'd0;
      end else if (ce) begin
         if (cnt_q == div_m1) begin
            shift_due = 1'b1;
            cnt_d     = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
      fb = mode_q ? (lfsr_q[TAP_A] ^ lfsr_q[TAP_B]) : lfsr_q[TAP_A];

      lfsr_d      = lfsr_q;
      mode_d      = mode_q;
      rate_d      = rate_q;
      shift_stb_d = 1'b0;
      // A control write wins over a coincident shift: the shift is simply dropped.
      if (ctrl_we) begin
         mode_d = ctrl_data[2];
         rate_d = ctrl_data[1:0];
         lfsr_d = SEED_V;
         cnt_d  = 8'd0;
      end else if (shift_due) begin
         shift_stb_d = 1'b1;
         if (lfsr_q == '0)
            lfsr_d = SEED_V;
         else
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
      end

      atten_d     = atten_we ? atten_data : atten_q;
      noise_out_d = lfsr_d[LFSR_W-1];
      level_d     = noise_out_d ? ~atten_d : 4'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q      <= SEED_V;
         cnt_q       <= 8'd0;
         mode_q      <= 1'b0;
         rate_q      <= 2'd0;
         atten_q     <= 4'hF;
         noise_out_q <= SEED_V[LFSR_W-1];
         shift_stb_q <= 1'b0;
         level_q     <= 4'd0;
      end else begin
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         rate_q      <= rate_d;
         atten_q     <= atten_d;
         noise_out_q <= noise_out_d;
         shift_stb_q <= shift_stb_d;
         level_q     <= level_d;
      end
   end

   assign noise_out = noise_out_q;
   assign shift_stb = shift_stb_q;
   assign level     = level_q;

endmodule

// File: tb/tb_sn_noise_channel.sv
// Self-checking bench for sn_noise_channel: directed scenarios plus a randomized run
// against a tick-counting reference model, and a 15-bit white-mode period sweep.
module tb_sn_noise_channel;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0, tone3_stb = 1'b0, ctrl_we = 1'b0, atten_we = 1'b0;
   logic [2:0] ctrl_data = 3'd0;
   logic [3:0] atten_data = 4'd0;
   logic       noise_out, shift_stb;
   logic [3:0] level;

   logic       tone2 = 1'b0, cwe2 = 1'b0;
   logic [2:0] cdata2 = 3'd0;
   logic       noise2, stb2;
   logic [3:0] level2;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [15:0] m_lfsr;
   int          m_ticks;
   logic        m_mode;
   logic [1:0]  m_rate;
   logic [3:0]  m_atten;
   logic        e_noise, e_stb;
   logic [3:0]  e_level;

   sn_noise_channel dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .tone3_stb(tone3_stb),
      .ctrl_we(ctrl_we), .ctrl_data(ctrl_data), .atten_we(atten_we),
      .atten_data(atten_data), .noise_out(noise_out), .shift_stb(shift_stb),
      .level(level)
   );

   sn_noise_channel #(.LFSR_W(15), .TAP_A(14), .TAP_B(13), .SEED(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .ce(1'b0), .tone3_stb(tone2),
      .ctrl_we(cwe2), .ctrl_data(cdata2), .atten_we(1'b0),
      .atten_data(4'd0), .noise_out(noise2), .shift_stb(stb2),
      .level(level2)
   );

   always #5 clk = ~clk;

   function automatic int div_of(input logic [1:0] r);
      return (r == 2'd0) ? 32 : (r == 2'd1) ? 64 : 128;
   endfunction

   function automatic logic [15:0] next_state(input logic [15:0] s, input logic white);
      int v, fb;
      v  = int'(s);
      fb = (v / 32768) % 2;
      if (white) fb = fb ^ ((v / 4096) % 2);
      return 16'(((v * 2) % 65536) + fb);
   endfunction

   task automatic model_reset();
      m_lfsr = 16'd1; m_ticks = 0; m_mode = 1'b0; m_rate = 2'd0; m_atten = 4'hF;
   endtask

   // Applies one clock of stimulus, advances the model, and leaves the bench #1 after the edge.
   task automatic cycle(input logic i_ce, input logic i_tone, input logic i_cwe,
                        input logic [2:0] i_cd, input logic i_awe, input logic [3:0] i_ad);
      ce = i_ce; tone3_stb = i_tone; ctrl_we = i_cwe; ctrl_data = i_cd;
      atten_we = i_awe; atten_data = i_ad;
      e_stb = 1'b0;
      if (i_cwe) begin
         m_mode = i_cd[2]; m_rate = i_cd[1:0]; m_lfsr = 16'd1; m_ticks = 0;
      end else if (m_rate == 2'd3) begin
         if (i_tone) begin
            m_lfsr = next_state(m_lfsr, m_mode); e_stb = 1'b1;
         end
      end else if (i_ce) begin
         m_ticks++;
         if (m_ticks == div_of(m_rate)) begin
            m_ticks = 0; m_lfsr = next_state(m_lfsr, m_mode); e_stb = 1'b1;
         end
      end
      if (i_awe) m_atten = i_ad;
      e_noise = m_lfsr[15];
      e_level = e_noise ? (4'hF - m_atten) : 4'd0;
      @(posedge clk);
      #1;
      ce = 1'b0; tone3_stb = 1'b0; ctrl_we = 1'b0; atten_we = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
      cycle(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 4'd0);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
      #2 rst_n = 1'b0;
      ctrl_we = 1'b1; ctrl_data = 3'b111;
      #1;
      total += 3;
      if (noise_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_noise got=%b exp=0", noise_out); end
      if (level !== 4'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
      if (shift_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb got=%b exp=0", shift_stb); end
      @(posedge clk); #1;
      total++;
      if (dut.lfsr_q !== 16'h0001) begin bad++; $display("[TB] FAIL reset_ctrl_ignored got=%h exp=0001", dut.lfsr_q); end
      ctrl_we = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      cycle(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 4'd0);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
      total += 2;
      if (noise_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_atten_noise got=%b exp=1", noise_out); end
      if (level !== 4'd0) begin bad++; $display("[TB] FAIL reset_atten_level got=%0d exp=0", level); end
   endtask

   task automatic test_periodic_rate3();
      cycle(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 4'd0);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
      total += 3;
      if (dut.lfsr_q !== 16'h8000) begin bad++; $display("[TB] FAIL per15_lfsr got=%h exp=8000", dut.lfsr_q); end
      if (noise_out !== 1'b1) begin bad++; $display("[TB] FAIL per15_noise got=%b exp=1", noise_out); end
      if (level !== 4'd15) begin bad++; $display("[TB] FAIL per15_level got=%0d exp=15", level); end
      cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
      total += 3;
      if (dut.lfsr_q !== 16'h0001) begin bad++; $display("[TB] FAIL per16_lfsr got=%h exp=0001", dut.lfsr_q); end
      if (noise_out !== 1'b0) begin bad++; $display("[TB] FAIL per16_noise got=%b exp=0", noise_out); end
      if (shift_stb !== 1'b1) begin bad++; $display("[TB] FAIL per16_stb got=%b exp=1", shift_stb); end
   endtask

   task automatic test_white_vs_periodic();
      cycle(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 4'd0);
      for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
      total++;
      if (dut.lfsr_q !== 16'h2001) begin bad++; $display("[TB] FAIL white13 got=%h exp=2001", dut.lfsr_q); end
      cycle(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 4'd0);
      for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
      total++;
      if (dut.lfsr_q !== 16'h2000) begin bad++; $display("[TB] FAIL periodic13 got=%h exp=2000", dut.lfsr_q); end
   endtask

   task automatic test_divider();
      int n, m, d;
      for (int r = 0; r < 3; r++) begin
         d = 32 << r;
         cycle(1'b1, 1'b0, 1'b1, {1'b1, 2'(r)}, 1'b0, 4'd0);
         n = 1;
         while (shift_stb !== 1'b1 && n < 400) begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
            n++;
         end
         total++;
         if (n != d + 1) begin bad++; $display("[TB] FAIL div%0d_first got=%0d exp=%0d", r, n, d + 1); end
         m = 0;
         do begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
            m++;
         end while (shift_stb !== 1'b1 && m < 400);
         total++;
         if (m != d) begin bad++; $display("[TB] FAIL div%0d_gap got=%0d exp=%0d", r, m, d); end
      end
   endtask

   task automatic test_collision();
      int n;
      cycle(1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 4'd0);
      for (int i = 0; i < 31; i++) cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
      cycle(1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 4'd0);
      total += 2;
      if (shift_stb !== 1'b0) begin bad++; $display("[TB] FAIL coll_stb got=%b exp=0", shift_stb); end
      if (dut.lfsr_q !== 16'h0001) begin bad++; $display("[TB] FAIL coll_lfsr got=%h exp=0001", dut.lfsr_q); end
      n = 1;
      while (shift_stb !== 1'b1 && n < 400) begin
         cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
         n++;
      end
      total++;
      if (n != 33) begin bad++; $display("[TB] FAIL coll_next got=%0d exp=33", n); end
   endtask

   task automatic test_random();
      logic       r_ce, r_tone, r_cwe, r_awe;
      logic [2:0] r_cd;
      logic [3:0] r_ad;
      for (int i = 0; i < 3000; i++) begin
         r_ce   = ($urandom_range(0, 1) == 1);
         r_tone = ($urandom_range(0, 3) == 0);
         r_cwe  = ($urandom_range(0, 59) == 0);
         r_cd   = 3'($urandom);
         r_awe  = ($urandom_range(0, 9) == 0);
         r_ad   = 4'($urandom);
         cycle(r_ce, r_tone, r_cwe, r_cd, r_awe, r_ad);
         total += 3;
         if (noise_out !== e_noise) begin bad++; $display("[TB] FAIL rnd_noise cyc=%0d got=%b exp=%b", i, noise_out, e_noise); end
         if (shift_stb !== e_stb) begin bad++; $display("[TB] FAIL rnd_stb cyc=%0d got=%b exp=%b", i, shift_stb, e_stb); end
         if (level !== e_level) begin bad++; $display("[TB] FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, e_level); end
      end
   endtask

   task automatic test_sweep();
      int s, first_ret, zero_seen, seq_bad;
      cwe2 = 1'b1; cdata2 = 3'b111;
      @(posedge clk); #1;
      cwe2 = 1'b0;
      s = 1; first_ret = 0; zero_seen = 0; seq_bad = 0;
      tone2 = 1'b1;
      for (int i = 1; i <= 32767; i++) begin
         @(posedge clk); #1;
         s = ((s * 2) % 32768) + (((s / 16384) + (s / 8192)) % 2);
         if (dut2.lfsr_q == 15'd0) zero_seen++;
         if (int'(dut2.lfsr_q) != s) seq_bad++;
         if (first_ret == 0 && dut2.lfsr_q == 15'd1) first_ret = i;
      end
      tone2 = 1'b0;
      total += 3;
      if (first_ret != 32767) begin bad++; $display("[TB] FAIL sweep_period got=%0d exp=32767", first_ret); end
      if (zero_seen != 0) begin bad++; $display("[TB] FAIL sweep_zero got=%0d exp=0", zero_seen); end
      if (seq_bad != 0) begin bad++; $display("[TB] FAIL sweep_seq got=%0d exp=0", seq_bad); end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      test_reset();
      test_periodic_rate3();
      test_white_vs_periodic();
      test_divider();
      test_collision();
      test_random();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
